vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Upstream stage of the VGA pixel path. Generates 640x480@60 raster timing from clk_in.
//  Outputs current_row/current_line/enable to the colour driver and hsync/vsync to the connector.
//  hsync/vsync are delayed to stay aligned with the driver's registered color_out.
//  Samples mouse position once per frame, in blanking, so the pointer never tears mid-frame.
// PARAMETERS
//  CLK_DIV     4    clk_in cycles per pixel (100 MHz -> 25 MHz); legal values >= 1
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   h front porch, pixels
//  H_SYNC      96   h sync width, pixels
//  H_BACK      48   h back porch, pixels (H_TOTAL = 800)
//  V_VISIBLE   480  visible lines
//  V_FRONT     10   v front porch, lines
//  V_SYNC      2    v sync width, lines
//  V_BACK      33   v back porch, lines (V_TOTAL = 525)
//  SYNC_DELAY  1    clk_in cycles of extra delay on hsync/vsync; legal values >= 0
// PORTS
//  clk_in          in   1   system clock
//  rst_n_in        in   1   asynchronous active-low reset
//  mouse_pos_x_in  in   10  live mouse x from PS/2 block
//  mouse_pos_y_in  in   10  live mouse y
//  current_row     out  10  pixel column counter h_cnt
//  current_line    out  10  line counter v_cnt
//  enable          out  1   1 when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE
//  hsync           out  1   active-low horizontal sync, delayed
//  vsync           out  1   active-low vertical sync, delayed
//  mouse_pos_x     out  10  frame-stable mouse x, clamped
//  mouse_pos_y     out  10  frame-stable mouse y, clamped
//  pixel_tick      out  1   1-clk strobe: counters advance on this edge
//  frame_start     out  1   1-clk strobe, coincident with counters wrapping to (0,0)
// BEHAVIOUR
//  Reset (async):
//   - div_cnt = 0.
//   - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so the first tick wraps to (0,0).
//   - enable = 0, hsync = vsync = 1 (whole delay line filled with 1).
//   - mouse_pos_x/y = 0; pixel_tick = frame_start = 0.
//  Divider:
//   - div_cnt counts 0..CLK_DIV-1 and wraps.
//   - pixel_tick is registered; it is 1 for the edge when div_cnt == CLK_DIV-1.
//   - With CLK_DIV = 1, pixel_tick stays high continuously.
//  Counters update only on tick edges and hold otherwise:
//   - h_cnt increments each tick; H_TOTAL-1 wraps to 0 and advances v_cnt.
//   - V_TOTAL-1 wraps to 0.
//  current_row/current_line are the counter registers themselves.
//   - enable is registered from the next counter values, so it changes on the same edge (0 lag).
//  Raw sync:
//   - hs_raw = 0 when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//   - vs_raw = 0 when v_cnt is in 490..491.
//   - Both come from the registered counters.
//   - Each passes through a shift register of SYNC_DELAY clk_in stages; SYNC_DELAY = 0 gives a direct path.
//  Mouse latch:
//   - Fires on the tick that moves v_cnt from V_VISIBLE-1 to V_VISIBLE (start of vblank).
//   - Samples the inputs; x > H_VISIBLE-1 clamps to H_VISIBLE-1, y > V_VISIBLE-1 clamps to V_VISIBLE-1.
//   - Outputs hold for the rest of the frame.
//  frame_start:
//   - Registered 1 on the tick edge where (h_cnt,v_cnt) becomes (0,0); 0 otherwise.
//   - Never asserted twice in one frame.
//  Reset mid-frame: all state returns to reset values immediately; no partial sync pulse is extended.
//  Widths: counters are 10 bit (max 799); compares are unsigned with no overflow.
// TESTING
//  1. Release reset, CLK_DIV=4 -> first pixel_tick 4 clk later; same edge: frame_start=1, row=0, line=0, enable=1.
//  2. Free-run one line -> hsync low for exactly 384 clk, falling 1 clk after h_cnt becomes 656; enable high 2560 clk/line.
//  3. Free-run one frame -> frame_start period 1,680,000 clk; vsync low 6400 clk; enable=0 on lines 480..524.
//  4. mouse_x_in=700, y=300 mid-frame, then x=100 before line 480 -> outputs unchanged until line 480, then (100,300); x=700 at latch -> 639.
//  5. Assert rst_n_in at row 700/line 491 (inside vsync) -> same-cycle hsync=vsync=1, enable=0; restart as test 1.
//  6. CLK_DIV=1, SYNC_DELAY=0 -> pixel_tick always 1; hsync low for 96 clk, aligned with h_cnt=656..751.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, delayed active-low syncs,
// and a once-per-frame mouse sample taken at the start of vertical blanking.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [9:0] mouse_pos_x_in,
  input  logic [9:0] mouse_pos_y_in,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] mouse_pos_x,
  output logic [9:0] mouse_pos_y,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [9:0]       h_cnt, v_cnt, h_nxt, v_nxt;
  logic             tick, latch_fire, frame_fire, en_nxt;
  logic             hs_raw, vs_raw;

  // Stage 0: divider and next-counter computation
  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    div_nxt    = tick ? '0 : div_cnt + 1'b1;
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    if (tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
    latch_fire = tick && (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
    frame_fire = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    en_nxt     = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // Stage 1: counter registers and their registered strobes
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt     <= '0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      enable      <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      mouse_pos_x <= '0;
      mouse_pos_y <= '0;
    end else begin
      div_cnt     <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      enable      <= en_nxt;
      pixel_tick  <= tick;
      frame_start <= frame_fire;
      if (latch_fire) begin
        mouse_pos_x <= clamp_pos(mouse_pos_x_in, H_VIS_LAST);
        mouse_pos_y <= clamp_pos(mouse_pos_y_in, V_VIS_LAST);
      end
    end
  end

  assign current_row  = h_cnt;
  assign current_line = v_cnt;

  // Stage 2: raw syncs decoded from the registered counters, then delayed
  assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign hsync = hs_raw;
      assign vsync = vs_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] hs_dly_p, vs_dly_p;
      // Delay line resets to all-ones so no sync pulse survives a reset.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          hs_dly_p <= '1;
          vs_dly_p <= '1;
        end else begin
          hs_dly_p <= (hs_dly_p << 1) | SYNC_DELAY'(hs_raw);
          vs_dly_p <= (vs_dly_p << 1) | SYNC_DELAY'(vs_raw);
        end
      end
      assign hsync = hs_dly_p[SYNC_DELAY-1];
      assign vsync = vs_dly_p[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-raster instances (divided and undivided pixel clock)
// compared every cycle against a model derived from the elapsed cycle count since reset.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int CD_A = 4, D_A = 1;
  localparam int CD_B = 1, D_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] mx_in = '0, my_in = '0;

  logic [9:0] row_a, line_a, mx_a, my_a, row_b, line_b, mx_b, my_b;
  logic       en_a, hs_a, vs_a, pt_a, fs_a, en_b, hs_b, vs_b, pt_b, fs_b;

  int k = 0;
  int n_checks = 0, n_errors = 0;
  int exp_mx_a = 0, exp_my_a = 0, exp_mx_b = 0, exp_my_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CD_A), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(D_A)
  ) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .mouse_pos_x_in(mx_in), .mouse_pos_y_in(my_in),
    .current_row(row_a), .current_line(line_a), .enable(en_a), .hsync(hs_a), .vsync(vs_a),
    .mouse_pos_x(mx_a), .mouse_pos_y(my_a), .pixel_tick(pt_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(CD_B), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(D_B)
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .mouse_pos_x_in(mx_in), .mouse_pos_y_in(my_in),
    .current_row(row_b), .current_line(line_b), .enable(en_b), .hsync(hs_b), .vsync(vs_b),
    .mouse_pos_x(mx_b), .mouse_pos_y(my_b), .pixel_tick(pt_b), .frame_start(fs_b)
  );

  // Reference: after k edges since reset release, k/cd pixel ticks have occurred; the
  // first tick lands on (0,0), so the raster position is (ticks - 1) modulo the frame.
  function automatic int pos_at(int kk, int cd);
    if (kk < 0) return TOT - 1;
    return ((kk / cd) + TOT - 1) % TOT;
  endfunction

  function automatic int tick_at(int kk, int cd);
    return (kk > 0 && (kk % cd) == 0) ? 1 : 0;
  endfunction

  function automatic int en_at(int kk, int cd);
    int p = pos_at(kk, cd);
    return ((p % HT) < HV && (p / HT) < VV) ? 1 : 0;
  endfunction

  function automatic int hs_at(int kk, int cd, int d);
    int h;
    if (kk - d < 0) return 1;
    h = pos_at(kk - d, cd) % HT;
    return (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
  endfunction

  function automatic int vs_at(int kk, int cd, int d);
    int v;
    if (kk - d < 0) return 1;
    v = pos_at(kk - d, cd) / HT;
    return (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
  endfunction

  function automatic int fs_at(int kk, int cd);
    return (tick_at(kk, cd) == 1 && pos_at(kk, cd) == 0) ? 1 : 0;
  endfunction

  function automatic int clamp_ref(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, k);
    end
  endtask

  task automatic check_all();
    check_val("a_row",   int'(row_a),  pos_at(k, CD_A) % HT);
    check_val("a_line",  int'(line_a), pos_at(k, CD_A) / HT);
    check_val("a_en",    int'(en_a),   en_at(k, CD_A));
    check_val("a_hsync", int'(hs_a),   hs_at(k, CD_A, D_A));
    check_val("a_vsync", int'(vs_a),   vs_at(k, CD_A, D_A));
    check_val("a_tick",  int'(pt_a),   tick_at(k, CD_A));
    check_val("a_fs",    int'(fs_a),   fs_at(k, CD_A));
    check_val("a_mx",    int'(mx_a),   exp_mx_a);
    check_val("a_my",    int'(my_a),   exp_my_a);
    check_val("b_row",   int'(row_b),  pos_at(k, CD_B) % HT);
    check_val("b_line",  int'(line_b), pos_at(k, CD_B) / HT);
    check_val("b_en",    int'(en_b),   en_at(k, CD_B));
    check_val("b_hsync", int'(hs_b),   hs_at(k, CD_B, D_B));
    check_val("b_vsync", int'(vs_b),   vs_at(k, CD_B, D_B));
    check_val("b_tick",  int'(pt_b),   tick_at(k, CD_B));
    check_val("b_fs",    int'(fs_b),   fs_at(k, CD_B));
    check_val("b_mx",    int'(mx_b),   exp_mx_b);
    check_val("b_my",    int'(my_b),   exp_my_b);
  endtask

  task automatic reset_checks();
    check_val("rst_a_row",  int'(row_a),  HT - 1);
    check_val("rst_a_line", int'(line_a), VT - 1);
    check_val("rst_a_en",   int'(en_a),   0);
    check_val("rst_a_hs",   int'(hs_a),   1);
    check_val("rst_a_vs",   int'(vs_a),   1);
    check_val("rst_a_tick", int'(pt_a),   0);
    check_val("rst_a_fs",   int'(fs_a),   0);
    check_val("rst_a_mx",   int'(mx_a),   0);
    check_val("rst_a_my",   int'(my_a),   0);
    check_val("rst_b_hs",   int'(hs_b),   1);
    check_val("rst_b_vs",   int'(vs_b),   1);
    check_val("rst_b_en",   int'(en_b),   0);
  endtask

  task automatic drive_mouse();
    mx_in = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 20));
    my_in = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 12));
  endtask

  // One clock: advance the model at the edge using the inputs the DUT sees, check at negedge.
  task automatic step();
    @(posedge clk);
    k++;
    if (tick_at(k, CD_A) == 1 && pos_at(k, CD_A) == VV * HT) begin
      exp_mx_a = clamp_ref(int'(mx_in), HV - 1);
      exp_my_a = clamp_ref(int'(my_in), VV - 1);
    end
    if (tick_at(k, CD_B) == 1 && pos_at(k, CD_B) == VV * HT) begin
      exp_mx_b = clamp_ref(int'(mx_in), HV - 1);
      exp_my_b = clamp_ref(int'(my_in), VV - 1);
    end
    @(negedge clk);
    check_all();
    drive_mouse();
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    drive_mouse();
    rst_n = 1'b1;
    k = 0;

    for (int i = 0; i < 2 * TOT * CD_A + 50; i++) step();

    // Walk into the vertical sync of instance A with hsync active, then reset mid-pulse.
    found = 1'b0;
    for (int i = 0; i < 2 * TOT * CD_A && !found; i++) begin
      step();
      if (pos_at(k, CD_A) == (VV + VF) * HT + HV + HF + 1) found = 1'b1;
    end
    check_val("reach_vsync", int'(found), 1);
    check_val("pre_rst_hs", int'(hs_a), 0);
    check_val("pre_rst_vs", int'(vs_a), 0);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    k = 0;
    exp_mx_a = 0; exp_my_a = 0; exp_mx_b = 0; exp_my_b = 0;
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    for (int i = 0; i < TOT * CD_A + 100; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
